// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The branch-target table is fixed at build time; retargeting a program means editing it here.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int LUT_AW      = 10;
  localparam int NUM_TARGETS = 8;

  localparam logic [LUT_AW-1:0] BRANCH_LUT [NUM_TARGETS] = '{
    10'd0, 10'd4, 10'd8, 10'd16, 10'd32, 10'd64, 10'd128, 10'd256
  };

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer (master) and the Start/Done, ROM and decoder
// environment (slave).
interface fetch_sequencer_if #(
  parameter int A     = 10,
  parameter int W     = 9,
  parameter int CYC_W = 16
);
  logic             start;
  logic             stall;
  logic [W-1:0]     inst_out;
  logic             branch_en;
  logic             branch_taken;
  logic [2:0]       target_sel;
  logic [A-1:0]     inst_address;
  logic             inst_valid;
  logic             done;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    input  start, stall, inst_out, branch_en, branch_taken, target_sel,
    output inst_address, inst_valid, done, cycle_count
  );

  modport slave (
    output start, stall, inst_out, branch_en, branch_taken, target_sel,
    input  inst_address, inst_valid, done, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// Combinational branch-target lookup: 3-bit selector to an A-bit ROM address.
module fetch_sequencer_branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int A = 10
) (
  input  logic [2:0]   target_sel,
  output logic [A-1:0] target
);

  assign target = A'(BRANCH_LUT[target_sel]);

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter / fetch controller: sequential fetch, LUT branches, stall hold,
// stop on the all-ones halt word, with a saturating count of RUN cycles.
//
// state | meaning
// IDLE  | after reset; outputs hold until Start
// RUN   | fetching; InstOut at InstAddress is live
// HALT  | halt word seen; Done high, PC and count frozen until Start/Reset
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int A          = 10,
  parameter int W          = 9,
  parameter int START_ADDR = 0,
  parameter int CYC_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  fetch_sequencer_if.master bus
);

  localparam logic [W-1:0] HALT_WORD = '1;

  fetch_state_t state;
  logic [A-1:0] branch_target;

  fetch_sequencer_branch_lut #(.A(A)) u_branch_lut (
    .target_sel (bus.target_sel),
    .target     (branch_target)
  );

  assign bus.inst_valid = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.inst_address <= A'(START_ADDR);
      bus.done         <= 1'b0;
      bus.cycle_count  <= '0;
    end else if (bus.start) begin
      state            <= RUN;
      bus.inst_address <= A'(START_ADDR);
      bus.done         <= 1'b0;
      bus.cycle_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          // Halt and stall edges still count as RUN cycles.
          if (bus.cycle_count != '1)
            bus.cycle_count <= bus.cycle_count + CYC_W'(1);
          if (bus.inst_out == HALT_WORD) begin
            state    <= HALT;
            bus.done <= 1'b1;
          end else if (bus.stall) begin
            bus.inst_address <= bus.inst_address;
          end else if (bus.branch_en && bus.branch_taken) begin
            bus.inst_address <= branch_target;
          end else begin
            bus.inst_address <= bus.inst_address + A'(1);
          end
        end
        HALT: begin
          bus.done <= 1'b1;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
